// File: rtl/sbox_seq_responder_if.sv
// Byte lookup bus between the SubBytes engine (master) and an S-box responder (slave).
// Carries the request fields plus the busy/data_valid handshake.
interface sbox_seq_responder_if;
  logic [7:0] addr;
  logic       chip_en;
  logic       read_en;
  logic       en_de;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;

  modport master (
    output addr, chip_en, read_en, en_de,
    input  data, data_valid, busy
  );

  modport slave (
    input  addr, chip_en, read_en, en_de,
    output data, data_valid, busy
  );
endinterface

// File: rtl/sbox_seq_responder.sv
// Table-free AES S-box responder: GF(2^8) inverse via x^254 square-and-multiply
// over seven steps, then the forward affine map (or inverse affine map applied first).
module sbox_seq_responder #(
  parameter bit HOLD_DATA = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sbox_seq_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXP, FIN} state_t;

  localparam logic [7:0] FWD_C = 8'h63;
  localparam logic [7:0] INV_D = 8'h05;

  state_t     state;
  logic [7:0] t;
  logic [7:0] acc;
  logic [7:0] data_q;
  logic [2:0] cnt;
  logic       mode;
  logic       data_valid_q;
  logic       busy_q;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Squaring is linear in GF(2^8): spread bits to even positions, then reduce by 0x11B.
  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    logic [14:0] s;
    s = 15'h0000;
    for (int i = 0; i < 8; i++) s[2*i] = a[i];
    for (int k = 14; k >= 8; k--) begin
      if (s[k]) s = s ^ (15'h011B << (k - 8));
    end
    return s[7:0];
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
           ^ b[(i + 7) % 8] ^ FWD_C[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ INV_D[i];
    end
    return r;
  endfunction

  // acc accumulates x^2 * x^4 * ... * x^128 = x^254, which is also 0 for input 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      t            <= 8'h00;
      acc          <= 8'h01;
      data_q       <= 8'h00;
      cnt          <= 3'd0;
      mode         <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.chip_en && bus.read_en && !busy_q) begin
            mode   <= bus.en_de;
            t      <= bus.en_de ? inv_affine(bus.addr) : bus.addr;
            acc    <= 8'h01;
            busy_q <= 1'b1;
            cnt    <= 3'd0;
            state  <= EXP;
          end
        end
        EXP: begin
          t   <= gf_sq(t);
          acc <= gf_mul(acc, gf_sq(t));
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) state <= FIN;
        end
        FIN: begin
          data_q       <= mode ? acc : fwd_affine(acc);
          data_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data       = (HOLD_DATA || data_valid_q) ? data_q : 8'h00;

endmodule

// File: tb/tb_sbox_seq_responder.sv
// Directed bench for sbox_seq_responder: known S-box vectors, round trip over all bytes,
// handshake timing, busy collisions, mid-lookup reset and request gating.
module tb_sbox_seq_responder;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sbox_seq_responder_if bus();
  sbox_seq_responder_if bus0();

  // Second instance without data hold sees exactly the same requests.
  assign bus0.addr    = bus.addr;
  assign bus0.chip_en = bus.chip_en;
  assign bus0.read_en = bus.read_en;
  assign bus0.en_de   = bus.en_de;

  sbox_seq_responder #(.HOLD_DATA(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sbox_seq_responder #(.HOLD_DATA(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge, then drops the strobes.
  task automatic applyStimulus(input logic [7:0] a, input logic dir);
    bus.addr    = a;
    bus.en_de   = dir;
    bus.chip_en = 1'b1;
    bus.read_en = 1'b1;
    @(posedge clk);
    #1;
    bus.chip_en = 1'b0;
    bus.read_en = 1'b0;
    checkOutput("accept_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_valid(input bit toggle, output logic [7:0] res, output int lat);
    lat = 0;
    while (lat < 20 && bus.data_valid !== 1'b1) begin
      if (toggle) begin
        bus.addr  = ~bus.addr;
        bus.en_de = ~bus.en_de;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.data;
  endtask

  task automatic do_lookup(input string tag, input logic [7:0] a, input logic dir,
                           input logic [7:0] exp, input bit toggle);
    logic [7:0] res;
    int         lat;
    applyStimulus(a, dir);
    checkOutput({tag, "_nohold_idle"}, {24'd0, bus0.data}, 32'd0);
    wait_valid(toggle, res, lat);
    checkOutput({tag, "_data"}, {24'd0, res}, {24'd0, exp});
    checkOutput({tag, "_latency"}, lat, 32'd8);
    checkOutput({tag, "_nohold_valid"}, {24'd0, bus0.data}, {24'd0, exp});
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_clear"}, {31'd0, bus.data_valid}, 32'd0);
    checkOutput({tag, "_hold"}, {24'd0, bus.data}, {24'd0, exp});
    checkOutput({tag, "_nohold_clear"}, {24'd0, bus0.data}, 32'd0);
    checkOutput({tag, "_busy_clear"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic lookup_raw(input logic [7:0] a, input logic dir,
                            output logic [7:0] res, output int lat);
    applyStimulus(a, dir);
    wait_valid(1'b0, res, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] fwd;
    int         lat;
    int         lat2;
    int         pulses;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.addr     = 8'h00;
    bus.en_de    = 1'b0;
    bus.chip_en  = 1'b0;
    bus.read_en  = 1'b0;

    #12;
    checkOutput("reset_data", {24'd0, bus.data}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.data_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forward and inverse reference vectors.
    do_lookup("fwd_00", 8'h00, 1'b0, 8'h63, 1'b0);
    do_lookup("fwd_01", 8'h01, 1'b0, 8'h7C, 1'b0);
    do_lookup("fwd_53", 8'h53, 1'b0, 8'hED, 1'b0);
    do_lookup("fwd_ff", 8'hFF, 1'b0, 8'h16, 1'b0);
    do_lookup("inv_ed", 8'hED, 1'b1, 8'h53, 1'b0);
    do_lookup("inv_63", 8'h63, 1'b1, 8'h00, 1'b0);
    do_lookup("inv_00", 8'h00, 1'b1, 8'h52, 1'b0);

    // Inputs wiggling during the lookup must not affect the sampled request.
    do_lookup("toggle_fwd", 8'h53, 1'b0, 8'hED, 1'b1);
    do_lookup("toggle_inv", 8'hED, 1'b1, 8'h53, 1'b1);

    // Round trip over every byte.
    for (int x = 0; x < 256; x++) begin
      lookup_raw(8'(x), 1'b0, fwd, lat);
      lookup_raw(fwd, 1'b1, res, lat2);
      checkOutput($sformatf("roundtrip_%02h", x), {24'd0, res}, x);
      checkOutput($sformatf("rt_fwd_lat_%02h", x), lat, 32'd8);
      checkOutput($sformatf("rt_inv_lat_%02h", x), lat2, 32'd8);
    end

    // A request three cycles into a lookup is dropped.
    applyStimulus(8'h53, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.addr    = 8'h10;
    bus.chip_en = 1'b1;
    bus.read_en = 1'b1;
    @(posedge clk);
    #1;
    bus.chip_en = 1'b0;
    bus.read_en = 1'b0;
    checkOutput("collision_busy", {31'd0, bus.busy}, 32'd1);
    wait_valid(1'b0, res, lat);
    checkOutput("collision_data", {24'd0, res}, 32'hED);
    checkOutput("collision_latency", lat, 32'd5);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.data_valid === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checkOutput("collision_no_second", pulses, 32'd0);

    // Request raised in the data_valid cycle is accepted straight away.
    applyStimulus(8'h01, 1'b0);
    wait_valid(1'b0, res, lat);
    checkOutput("b2b_first_data", {24'd0, res}, 32'h7C);
    applyStimulus(8'h00, 1'b0);
    wait_valid(1'b0, res, lat);
    checkOutput("b2b_second_data", {24'd0, res}, 32'h63);
    checkOutput("b2b_gap", lat + 1, 32'd9);
    @(posedge clk);
    #1;

    // Reset in the middle of a lookup.
    applyStimulus(8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #2;
    checkOutput("midreset_data", {24'd0, bus.data}, 32'd0);
    checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midreset_valid", {31'd0, bus.data_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.data_valid === 1'b1) pulses++;
    end
    checkOutput("midreset_no_pulse", pulses, 32'd0);
    do_lookup("after_reset", 8'h01, 1'b0, 8'h7C, 1'b0);

    // Half-asserted requests are never accepted.
    bus.chip_en = 1'b0;
    bus.read_en = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0) pulses++;
    end
    checkOutput("gate_chip_en", pulses, 32'd0);
    bus.chip_en = 1'b1;
    bus.read_en = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0) pulses++;
    end
    checkOutput("gate_read_en", pulses, 32'd0);
    bus.chip_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sbox_seq_responder.md
Name: sbox_seq_responder

Overview:
- Iterative, table-free S-box responder on the byte lookup interface that the SubBytes engine drives: addr, chip_en, read_en, en_de in; data out.
- Computes the forward or inverse AES S-box by GF(2^8) inversion (x^254, square-and-multiply) plus the affine transform.
- Drop-in alternative to the ROM when area matters; adds busy/data_valid so the initiator can handshake instead of assuming a one-cycle ROM read.

Parameters:
- HOLD_DATA, 1, 1: data holds the last result until the next result is written; 0: data is forced to 8'h00 in every cycle data_valid is low.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- addr  input  8  byte to substitute
- chip_en  input  1  responder select
- read_en  input  1  lookup request strobe; a request needs chip_en=1 and read_en=1
- en_de  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt)
- data  output  8  substituted byte
- data_valid  output  1  one-cycle pulse; data is valid in that cycle
- busy  output  1  lookup in progress; requests are ignored while high

Behaviour:
- Reset (asynchronous, any state): state=IDLE, data=8'h00, data_valid=0, busy=0, internal t=0, acc=8'h01, mode=0. An in-flight lookup is discarded with no valid pulse. The first request is accepted on the first rising edge after rst deasserts.
- Field rules:
  - Polynomial 0x11B.
  - gf_mul is a full 8x8 combinational multiply.
  - gf_sq is a linear squaring.
  - Forward affine: b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, c = 8'h63, indices mod 8.
  - Inverse affine: b'_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i, d = 8'h05.
- FSM states: IDLE, EXP, FIN.
- IDLE:
  - Accept condition: chip_en & read_en & ~busy at a rising edge (edge N).
  - On accept: mode <= en_de; t <= en_de ? inv_affine(addr) : addr; acc <= 8'h01; busy <= 1; cnt <= 0; go to EXP.
  - addr and en_de are sampled only at edge N. Later changes on them have no effect on the lookup.
- EXP (edges N+1..N+7, cnt 0..6):
  - Each edge: t <= gf_sq(t); acc <= gf_mul(acc, gf_sq(t)); cnt <= cnt+1.
  - Go to FIN when cnt == 6.
  - Result after 7 steps: acc = x^(2+4+...+128) = x^254 = x^-1. Input 0 yields 0 naturally, so no special case is needed.
- FIN (edge N+8):
  - data <= mode ? acc : fwd_affine(acc); data_valid <= 1; busy <= 0; go to IDLE.
- Latency: request accepted at edge N, data_valid high in the cycle following edge N+8 (8 clocks). Throughput is one lookup per 9 cycles.
  - A new request is accepted at edge N+9, the cycle in which data_valid is high.
- data_valid is cleared on the next edge unless another FIN occurs. It is never high for two consecutive cycles.
- Requests while busy=1 are dropped, not queued. The initiator must hold chip_en/read_en until it sees busy rise, or re-issue the request.
- chip_en=0 during EXP/FIN does not abort the lookup.
- read_en=1 with chip_en=0, or chip_en=1 with read_en=0, is never accepted.
- HOLD_DATA=0: data reads 8'h00 in every cycle data_valid=0.

Test Plan:
- Forward: addr=8'h00, en_de=0 -> data=8'h63 with data_valid exactly 8 cycles after accept. Also 8'h01 -> 8'h7C, 8'h53 -> 8'hED, 8'hFF -> 8'h16.
- Inverse: en_de=1, addr=8'hED -> 8'h53; 8'h63 -> 8'h00; 8'h00 -> 8'h52.
- Exhaustive round trip: for all 256 x, forward then inverse lookup returns x. busy/data_valid timing is identical for every x.
- Busy collision: issue a second request with addr=8'h10 three cycles after accepting 8'h53 -> ignored, single pulse with 8'hED. Back-to-back request asserted in the data_valid cycle -> accepted, second result 9 cycles after the first.
- Reset mid-op: assert rst at cnt=3 -> data=8'h00, busy=0, no valid pulse. After release, request 8'h01 -> 8'h7C at nominal latency.
- Input stability and gating: toggle addr and en_de every cycle during EXP -> result matches the values sampled at accept. chip_en=0 with read_en=1 for 20 cycles -> busy stays 0.
